// File: rtl/press_counter_controller.sv
`default_nettype none
// ============================================================================
//  Module   : press_counter_controller
//  Purpose  : Bounded up/down counter driven by debounced press pulses
//             (clear > increment > decrement).  Optional hold-to-repeat
//             stepping from the debounced held levels.
//  Options  : define PRESS_COUNTER_AUTO_REPEAT_EN to build the
//             HOLD_WAIT/REPEAT states and the repeat timer.
//  Revision : 1.0  initial release
// ============================================================================
module press_counter_controller #(
   parameter int WIDTH         = 4,
   parameter int MAX_COUNT     = 9,
   parameter int HOLD_CYCLES   = 1000000,
   parameter int REPEAT_CYCLES = 250000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             incPulse,
   input  logic             decPulse,
   input  logic             clrPulse,
   input  logic             incHeld,
   input  logic             decHeld,
   output logic [WIDTH-1:0] count,
   output logic             countChanged,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             auto_step;
   logic             dir_inc;
   logic             step_inc;
   logic [WIDTH-1:0] count_nxt;
   logic             changed_nxt;
   logic             wrapped_nxt;

`ifdef PRESS_COUNTER_AUTO_REPEAT_EN
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEAT    = 2'd2
   } state_t;

   // Timer only needs to hold the larger of the two reload values.
   localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
   localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REPEAT_LOAD = TIMER_W'(REPEAT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

   state_t               state, state_nxt;
   logic [TIMER_W-1:0]   timer, timer_nxt;
   logic                 dir_inc_nxt;
   logic                 held;

   // Repeat FSM state, timer and latched direction.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         dir_inc <= 1'b1;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         dir_inc <= dir_inc_nxt;
      end
   end

   // Next-state logic: pulses restart the hold window, held level gates expiry.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      dir_inc_nxt = dir_inc;
      auto_step   = 1'b0;
      held        = dir_inc ? incHeld : decHeld;
      if (clrPulse) begin
         state_nxt = IDLE;
         timer_nxt = '0;
      end else if (incPulse || decPulse) begin
         state_nxt   = HOLD_WAIT;
         timer_nxt   = HOLD_LOAD;
         dir_inc_nxt = incPulse;
      end else begin
         case (state)
            IDLE: ;
            HOLD_WAIT, REPEAT: begin
               // Held level is checked first: a release on the expiry edge
               // suppresses the step.
               if (!held) begin
                  state_nxt = IDLE;
               end else if (timer != '0) begin
                  timer_nxt = timer - TIMER_ONE;
               end else begin
                  auto_step = 1'b1;
                  timer_nxt = REPEAT_LOAD;
                  state_nxt = REPEAT;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end
`else
   logic unused_repeat_inputs;

   // Without auto-repeat the held levels and timing parameters have no effect.
   assign auto_step            = 1'b0;
   assign dir_inc              = 1'b1;
   assign unused_repeat_inputs = incHeld | decHeld | (HOLD_CYCLES < 1) | (REPEAT_CYCLES < 1);
`endif

   // A pulse picks the direction; otherwise an auto step uses the latched one.
   assign step_inc = incPulse | (~decPulse & dir_inc);

   // Next count value with wrap detection; clear outranks any step.
   always_comb begin
      count_nxt   = count;
      changed_nxt = 1'b0;
      wrapped_nxt = 1'b0;
      if (clrPulse) begin
         count_nxt   = '0;
         changed_nxt = (count != '0);
      end else if (incPulse || decPulse || auto_step) begin
         changed_nxt = 1'b1;
         if (step_inc) begin
            if (count == MAX_VAL) begin
               count_nxt   = '0;
               wrapped_nxt = 1'b1;
            end else begin
               count_nxt = count + ONE;
            end
         end else begin
            if (count == '0) begin
               count_nxt   = MAX_VAL;
               wrapped_nxt = 1'b1;
            end else begin
               count_nxt = count - ONE;
            end
         end
      end
   end

   // Registered count and the one-cycle change/wrap pulses aligned with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         count        <= '0;
         countChanged <= 1'b0;
         wrapped      <= 1'b0;
      end else begin
         count        <= count_nxt;
         countChanged <= changed_nxt;
         wrapped      <= wrapped_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_press_counter_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_press_counter_controller
//  Purpose  : Self-checking bench for press_counter_controller (WIDTH=4,
//             MAX_COUNT=9, HOLD_CYCLES=4, REPEAT_CYCLES=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_press_counter_controller;

   localparam int WIDTH  = 4;
   localparam int MAXC   = 9;
   localparam int HOLD   = 4;
   localparam int REP    = 2;
`ifdef PRESS_COUNTER_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic             clock;
   logic             reset;
   logic             incPulse, decPulse, clrPulse, incHeld, decHeld;
   logic [WIDTH-1:0] count;
   logic             countChanged, wrapped;

   int checks = 0;
   int passes = 0;

   // Reference model state: counter as plain integer, hold tracked as
   // elapsed edges since the most recent inc/dec press.
   int m_count;
   bit m_chg, m_wr, m_active, m_dir;
   int m_k;

   typedef struct {
      bit         rst, inc, dec, clr;
      logic [3:0] cnt;
      bit         chg, wr;
   } vec_t;
   vec_t tbl[$];

   press_counter_controller #(
      .WIDTH(WIDTH), .MAX_COUNT(MAXC), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
   ) dut (
      .clock(clock), .reset(reset),
      .incPulse(incPulse), .decPulse(decPulse), .clrPulse(clrPulse),
      .incHeld(incHeld), .decHeld(decHeld),
      .count(count), .countChanged(countChanged), .wrapped(wrapped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic apply_step(input int d);
      int nc;
      nc = m_count + d;
      m_chg = 1'b1;
      if (nc > MAXC) begin nc = 0; m_wr = 1'b1; end
      else if (nc < 0) begin nc = MAXC; m_wr = 1'b1; end
      m_count = nc;
   endtask

   task automatic model_edge(input bit r, i, d, c, ih, dh);
      if (r) begin
         m_count = 0; m_chg = 0; m_wr = 0; m_active = 0; m_k = 0; m_dir = 1;
      end else begin
         m_chg = 0; m_wr = 0;
         if (c) begin
            m_chg = (m_count != 0); m_count = 0; m_active = 0;
         end else if (i || d) begin
            apply_step(i ? 1 : -1);
            m_dir = i; m_k = 0; m_active = AUTO;
         end else if (m_active) begin
            m_k++;
            if (!(m_dir ? ih : dh)) m_active = 0;
            else if (m_k == HOLD || (m_k > HOLD && (m_k - HOLD) % REP == 0))
               apply_step(m_dir ? 1 : -1);
         end
      end
   endtask

   task automatic chk3(input string nm, input logic [3:0] ec, input logic ech, input logic ew);
      checks++;
      if (count === ec && countChanged === ech && wrapped === ew) passes++;
      else $display("FAIL %s: got count=%0d changed=%0b wrapped=%0b, expected count=%0d changed=%0b wrapped=%0b",
                    nm, count, countChanged, wrapped, ec, ech, ew);
   endtask

   // One clock: drive inputs, let the edge happen, update model, compare.
   task automatic cyc(input bit r, i, d, c, ih, dh);
      reset = r; incPulse = i; decPulse = d; clrPulse = c; incHeld = ih; decHeld = dh;
      @(posedge clock);
      model_edge(r, i, d, c, ih, dh);
      #1;
      chk3("model", 4'(m_count), m_chg, m_wr);
      @(negedge clock);
   endtask

   task automatic add(input bit r, i, d, c, input int n, input bit ch, w);
      vec_t v;
      v.rst = r; v.inc = i; v.dec = d; v.clr = c; v.cnt = 4'(n); v.chg = ch; v.wr = w;
      tbl.push_back(v);
   endtask

   initial begin
      bit ih, dh;
      reset = 1'b1; incPulse = 0; decPulse = 0; clrPulse = 0; incHeld = 0; decHeld = 0;
      m_count = 0; m_chg = 0; m_wr = 0; m_active = 0; m_k = 0; m_dir = 1;

      // Fixed vectors: wrap on increment/decrement, clear, priority.
      add(1, 0, 0, 0, 0, 0, 0);
      for (int n = 1; n <= 9; n++) add(0, 1, 0, 0, n, 1, 0);
      add(0, 1, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 9, 1, 1);
      add(0, 0, 0, 1, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0);
      for (int n = 1; n <= 5; n++) add(0, 1, 0, 0, n, 1, 0);
      add(0, 1, 1, 1, 0, 1, 0);
      for (int n = 1; n <= 5; n++) add(0, 1, 0, 0, n, 1, 0);
      add(0, 1, 1, 0, 6, 1, 0);
      add(0, 0, 1, 0, 5, 1, 0);
      add(0, 0, 0, 0, 5, 0, 0);
      add(0, 0, 1, 1, 0, 1, 0);

      @(negedge clock);
      foreach (tbl[k]) begin
         cyc(tbl[k].rst, tbl[k].inc, tbl[k].dec, tbl[k].clr, 1'b0, 1'b0);
         chk3($sformatf("vec%0d", k), tbl[k].cnt, tbl[k].chg, tbl[k].wr);
      end

      // Hold-to-repeat: held through N+9 gives steps at N, N+4, N+6, N+8.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 0);
      for (int k = 0; k < 9; k++) cyc(0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0);
      chk3("hold_repeat", AUTO ? 4'd4 : 4'd1, 1'b0, 1'b0);

      // Release before the first repeat: only the press step.
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 1, 0);
      for (int k = 0; k < 2; k++) cyc(0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 0);
      chk3("early_release", 4'd1, 1'b0, 1'b0);

      // Reset while repeating returns to IDLE: no further steps while held.
      cyc(0, 1, 0, 0, 1, 0);
      for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk3("reset_in_repeat", 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1, 0);
      chk3("after_reset_hold", 4'd0, 1'b0, 1'b0);

      // Decrement pulse during an increment repeat relatches direction.
      cyc(0, 1, 0, 0, 1, 0);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 1, 0);
      for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 0);
      chk3("dec_no_held", AUTO ? 4'd1 : 4'd0, 1'b0, 1'b0);
      cyc(0, 0, 1, 0, 0, 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) cyc(0, 0, 0, 0, 0, 0);
      chk3("dec_repeat", 4'd9, 1'b0, 1'b0);

      // Randomised traffic against the model.
      ih = 0; dh = 0;
      for (int k = 0; k < 600; k++) begin
         int sel;
         bit r, i, d, c;
         sel = $urandom_range(0, 19);
         r = ($urandom_range(0, 99) == 0);
         i = (sel == 0) || (sel == 3) || (sel == 5);
         d = (sel == 1) || (sel == 3) || (sel == 4);
         c = (sel == 2) || (sel == 5);
         if ($urandom_range(0, 7) == 0) ih = ~ih;
         if ($urandom_range(0, 7) == 0) dh = ~dh;
         cyc(r, i, d, c, ih, dh);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
